// File: rtl/puf_resp_ctrl.sv
// puf_resp_ctrl: windowed ring-oscillator pair comparator. For each response
// bit it selects an oscillator pair from the challenge seed, waits for the
// pair to settle, counts synchronized rising edges of both over a fixed
// window, and records count_a > count_b as that bit of the response.
//
// Handshake: start is a request that is accepted only while busy=0 (IDLE);
// requests made while busy are dropped. done is a one-cycle valid strobe for
// response/tie/sat/last_a/last_b, which then hold until the next accepted
// start. There is no back-pressure on done.
module puf_resp_ctrl #(
  parameter int NBITS         = 16,
  parameter int CW            = 16,
  parameter int WIN_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic [3:0]       sel_a,
  output logic [3:0]       sel_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] response,
  output logic             tie,
  output logic             sat,
  output logic [CW-1:0]    last_a,
  output logic [CW-1:0]    last_b
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int PMAX = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int TW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  // state_q is the FSM state; probe it hierarchically when debugging
  state_t          state_q, state_d;
  logic [TW-1:0]   phase_q;
  logic [4:0]      bit_q;
  logic [7:0]      seed_q;
  logic [2:0]      sync_a, sync_b;
  logic [CW-1:0]   cnt_a, cnt_b;

  logic            edge_a, edge_b;
  logic            phase_done;
  logic            last_bit;
  logic            start_acc;
  logic [3:0]      sel_nxt;

  // A zero upper nibble would make sel_b == sel_a, so it maps to key 1
  function automatic logic [3:0] key_of(input logic [7:0] s);
    return (s[7:4] == 4'h0) ? 4'h1 : s[7:4];
  endfunction

  assign edge_a     = sync_a[1] & ~sync_a[2];
  assign edge_b     = sync_b[1] & ~sync_b[2];
  assign phase_done = ((state_q == S_SETTLE)  && (phase_q == TW'(SETTLE_CYCLES - 1))) ||
                      ((state_q == S_MEASURE) && (phase_q == TW'(WIN_CYCLES - 1)));
  assign last_bit   = (bit_q == 5'(NBITS - 1));
  assign start_acc  = (state_q == S_IDLE) && start;
  assign sel_nxt    = seed_q[3:0] + bit_q[3:0] + 4'd1;

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SETTLE;
      S_SETTLE:  if (phase_done) state_d = S_MEASURE;
      S_MEASURE: if (phase_done) state_d = S_COMPARE;
      S_COMPARE: state_d = last_bit ? S_DONE : S_SETTLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    busy  = 1'b0;
    ro_en = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_SETTLE, S_MEASURE, S_COMPARE: begin
        busy  = 1'b1;
        ro_en = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Two-FF synchronizers plus an edge-detect stage for each oscillator
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_a <= 3'b000;
      sync_b <= 3'b000;
    end else begin
      sync_a <= {sync_a[1:0], ro_a};
      sync_b <= {sync_b[1:0], ro_b};
    end
  end

  // Phase timer for SETTLE/MEASURE, bit index, latched seed and mux selects
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_q <= '0;
      bit_q   <= '0;
      seed_q  <= '0;
      sel_a   <= '0;
      sel_b   <= '0;
    end else begin
      if (((state_q == S_SETTLE) || (state_q == S_MEASURE)) && !phase_done)
        phase_q <= phase_q + TW'(1);
      else
        phase_q <= '0;
      if (start_acc) begin
        bit_q  <= '0;
        seed_q <= seed;
        sel_a  <= seed[3:0];
        sel_b  <= seed[3:0] ^ key_of(seed);
      end else if ((state_q == S_COMPARE) && !last_bit) begin
        bit_q  <= bit_q + 5'd1;
        sel_a  <= sel_nxt;
        sel_b  <= sel_nxt ^ key_of(seed_q);
      end
    end
  end

  // Saturating edge counters, live only during MEASURE and zero otherwise
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state_q == S_MEASURE) begin
      if (edge_a && (cnt_a != CMAX)) cnt_a <= cnt_a + CW'(1);
      if (edge_b && (cnt_b != CMAX)) cnt_b <= cnt_b + CW'(1);
    end else begin
      cnt_a <= '0;
      cnt_b <= '0;
    end
  end

  // Result registers: cleared on accepted start, updated in COMPARE
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      response <= '0;
      tie      <= 1'b0;
      sat      <= 1'b0;
      last_a   <= '0;
      last_b   <= '0;
    end else if (start_acc) begin
      response <= '0;
      tie      <= 1'b0;
      sat      <= 1'b0;
    end else begin
      if ((state_q == S_MEASURE) &&
          ((edge_a && (cnt_a == CMAX)) || (edge_b && (cnt_b == CMAX))))
        sat <= 1'b1;
      if (state_q == S_COMPARE) begin
        response <= response | (NBITS'(cnt_a > cnt_b) << bit_q);
        if (cnt_a == cnt_b) tie <= 1'b1;
        last_a   <= cnt_a;
        last_b   <= cnt_b;
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Bench for puf_resp_ctrl: one 16-bit-counter instance and one 4-bit-counter
// instance share all stimulus. Oscillators are modelled as square waves whose
// period is chosen per response bit; expected counts are window/period.
module tb_puf_resp_ctrl;

  localparam int NB  = 4;
  localparam int WIN = 64;
  localparam int SET = 8;
  localparam int BIT_CYC = SET + WIN + 1;
  localparam int LAT = NB * BIT_CYC + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    seed;
  logic          ro_a, ro_b;

  logic [3:0]    sel_a, sel_b;
  logic          ro_en, busy, done, tie, sat;
  logic [NB-1:0] response;
  logic [15:0]   last_a, last_b;

  logic [3:0]    s_sel_a, s_sel_b;
  logic          s_ro_en, s_busy, s_done, s_tie, s_sat;
  logic [NB-1:0] s_response;
  logic [3:0]    s_last_a, s_last_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  int pa_tab [NB];
  int pb_tab [NB];
  bit same_tab [NB];

  logic [3:0] sa_set [NB], sb_set [NB], sa_mid [NB], sb_mid [NB];
  logic       busy_mid [NB], en_mid [NB];

  logic [NB-1:0] exp_q[$];

  puf_resp_ctrl #(.NBITS(NB), .CW(16), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .busy(busy), .done(done),
    .response(response), .tie(tie), .sat(sat), .last_a(last_a), .last_b(last_b)
  );

  puf_resp_ctrl #(.NBITS(NB), .CW(4), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(s_sel_a), .sel_b(s_sel_b), .ro_en(s_ro_en), .busy(s_busy), .done(s_done),
    .response(s_response), .tie(s_tie), .sat(s_sat), .last_a(s_last_a), .last_b(s_last_b)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: per-bit square-wave periods (0 = stuck low)
  initial begin
    int ca, cb, idx;
    ca = 0; cb = 0;
    ro_a = 1'b0; ro_b = 1'b0;
    forever begin
      @(posedge clk); #2;
      idx = (cyc - base) / BIT_CYC;
      if (idx < 0) idx = 0;
      if (idx > NB - 1) idx = NB - 1;
      if (pa_tab[idx] == 0) ro_a = 1'b0;
      else begin
        ca++;
        if (ca >= pa_tab[idx] / 2) begin ro_a = ~ro_a; ca = 0; end
      end
      if (same_tab[idx]) ro_b = ro_a;
      else if (pb_tab[idx] == 0) ro_b = 1'b0;
      else begin
        cb++;
        if (cb >= pb_tab[idx] / 2) begin ro_b = ~ro_b; cb = 0; end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules
  function automatic logic [3:0] ref_sel_a(input logic [7:0] s, input int i);
    return 4'((int'(s[3:0]) + i) % 16);
  endfunction

  function automatic logic [3:0] ref_sel_b(input logic [7:0] s, input int i);
    int k;
    k = (s[7:4] == 4'h0) ? 1 : int'(s[7:4]);
    return ref_sel_a(s, i) ^ 4'(k);
  endfunction

  function automatic int ref_cnt(input int p);
    return (p == 0) ? 0 : WIN / p;
  endfunction

  // Driver tasks
  task automatic set_all(input int pa, input int pb, input bit same);
    for (int i = 0; i < NB; i++) begin
      pa_tab[i] = pa; pb_tab[i] = pb; same_tab[i] = same;
    end
  endtask

  task automatic do_start(input logic [7:0] s);
    @(posedge clk); #1;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    base  = cyc;
    start = 1'b0;
    seed  = 8'hFF;
  endtask

  // Runs one generation; lat is the cycle count (start edge = 1) at which
  // done was seen, or -1 if it never came. Optionally pokes start mid-run.
  task automatic run_cmd(input logic [7:0] s, input bit poke, output int lat);
    int n;
    lat = -1;
    do_start(s);
    n = 1;
    while (n < LAT + 100) begin
      if (done) begin lat = n; break; end
      if ((n % BIT_CYC) == 2 && (n / BIT_CYC) < NB) begin
        sa_set[n / BIT_CYC] = sel_a; sb_set[n / BIT_CYC] = sel_b;
      end
      if ((n % BIT_CYC) == 40 && (n / BIT_CYC) < NB) begin
        sa_mid[n / BIT_CYC] = sel_a; sb_mid[n / BIT_CYC] = sel_b;
        busy_mid[n / BIT_CYC] = busy; en_mid[n / BIT_CYC] = ro_en;
      end
      if (poke && n == 150) begin start = 1'b1; seed = 8'h77; end
      if (poke && n == 151) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n_act;
    total++;
    if (busy !== 1'b0 || ro_en !== 1'b0 || done !== 1'b0 || response !== '0 ||
        tie !== 1'b0 || sat !== 1'b0 || sel_a !== 4'h0 || sel_b !== 4'h0 ||
        last_a !== 16'h0 || last_b !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b ro_en=%b done=%b resp=%h tie=%b sat=%b sel=%h/%h last=%0d/%0d want all zero",
               busy, ro_en, done, response, tie, sat, sel_a, sel_b, last_a, last_b);
    end
    rst_n = 1'b0;
    set_all(4, 8, 1'b0);
    do_start(8'h00);
    repeat (3 * BIT_CYC + 30 - 1) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || response[2:0] !== 3'b111) begin
      bad++;
      $display("FAIL reset_premeasure: busy=%b resp=%b want busy=1 resp[2:0]=111", busy, response);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || ro_en !== 1'b0 || response !== '0 || sel_a !== 4'h0 || last_a !== 16'h0) begin
      bad++;
      $display("FAIL reset_midrun: busy=%b ro_en=%b resp=%b sel_a=%h last_a=%0d want all zero",
               busy, ro_en, response, sel_a, last_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    n_act = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy || ro_en || done) n_act++;
    end
    total++;
    if (n_act != 0) begin
      bad++;
      $display("FAIL reset_stays_idle: active_cycles=%0d want 0", n_act);
    end
  endtask

  task automatic test_basic();
    int lat;
    bit ok;
    set_all(4, 8, 1'b0);
    run_cmd(8'h00, 1'b0, lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (response !== 4'b1111 || tie !== 1'b0) begin
      bad++; $display("FAIL basic_response: resp=%b tie=%b want 1111 tie=0", response, tie);
    end
    total++;
    if (last_a < 15 || last_a > 17 || last_b < 7 || last_b > 9) begin
      bad++; $display("FAIL basic_counts: last_a=%0d last_b=%0d want 16+-1 8+-1", last_a, last_b);
    end
    ok = 1'b1;
    for (int i = 0; i < NB; i++)
      if (sa_mid[i] !== ref_sel_a(8'h00, i) || sb_mid[i] !== ref_sel_b(8'h00, i) ||
          busy_mid[i] !== 1'b1 || en_mid[i] !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL basic_measure_outputs: sel_a0=%h sel_b0=%h busy=%b en=%b want 0/1/1/1",
                      sa_mid[0], sb_mid[0], busy_mid[0], en_mid[0]);
    end
    total++;
    if (busy !== 1'b0 || ro_en !== 1'b0) begin
      bad++; $display("FAIL basic_done_flags: busy=%b ro_en=%b want 0/0", busy, ro_en);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_challenge();
    int lat;
    set_all(8, 16, 1'b0);
    run_cmd(8'h3E, 1'b0, lat);
    for (int i = 0; i < NB; i++) begin
      total++;
      if (sa_set[i] !== ref_sel_a(8'h3E, i) || sb_set[i] !== ref_sel_b(8'h3E, i) ||
          sa_mid[i] !== ref_sel_a(8'h3E, i) || sb_mid[i] !== ref_sel_b(8'h3E, i)) begin
        bad++;
        $display("FAIL challenge_sel bit%0d: settle=%h/%h measure=%h/%h want %h/%h", i,
                 sa_set[i], sb_set[i], sa_mid[i], sb_mid[i], ref_sel_a(8'h3E, i), ref_sel_b(8'h3E, i));
      end
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (sel_a !== 4'h1 || sel_b !== 4'h2) begin
      bad++; $display("FAIL challenge_idle_hold: sel=%h/%h want 1/2", sel_a, sel_b);
    end
  endtask

  task automatic test_tie_order();
    int lat;
    set_all(8, 8, 1'b1);
    run_cmd(8'h05, 1'b0, lat);
    total++;
    if (response !== '0 || tie !== 1'b1 || last_a !== last_b) begin
      bad++; $display("FAIL tie_same: resp=%b tie=%b last=%0d/%0d want 0 1 equal", response, tie, last_a, last_b);
    end
    total++;
    if (sa_mid[2] !== 4'h7 || sb_mid[2] !== 4'h6) begin
      bad++; $display("FAIL tie_sel: sel=%h/%h want 7/6", sa_mid[2], sb_mid[2]);
    end
    set_all(16, 4, 1'b0);
    run_cmd(8'h05, 1'b0, lat);
    total++;
    if (response !== '0 || tie !== 1'b0) begin
      bad++; $display("FAIL order_b_faster: resp=%b tie=%b want 0 0", response, tie);
    end
  endtask

  task automatic test_saturation();
    int lat;
    set_all(4, 0, 1'b0);
    run_cmd(8'hA9, 1'b0, lat);
    total++;
    if (s_last_a !== 4'd15 || s_sat !== 1'b1 || s_response !== 4'b1111 || s_tie !== 1'b0) begin
      bad++; $display("FAIL sat_set: last_a=%0d sat=%b resp=%b tie=%b want 15 1 1111 0",
                      s_last_a, s_sat, s_response, s_tie);
    end
    total++;
    if (sat !== 1'b0 || response !== 4'b1111) begin
      bad++; $display("FAIL sat_wide_counter: sat=%b resp=%b want 0 1111", sat, response);
    end
    set_all(16, 32, 1'b0);
    run_cmd(8'hA9, 1'b0, lat);
    total++;
    if (s_sat !== 1'b0 || s_response !== 4'b1111 || s_last_a < 3 || s_last_a > 5) begin
      bad++; $display("FAIL sat_cleared: sat=%b resp=%b last_a=%0d want 0 1111 4+-1", s_sat, s_response, s_last_a);
    end
  endtask

  task automatic test_start_busy();
    int lat, n_done;
    bit ok;
    set_all(8, 4, 1'b0);
    run_cmd(8'h12, 1'b1, lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT); end
    ok = 1'b1;
    for (int i = 0; i < NB; i++)
      if (sa_mid[i] !== ref_sel_a(8'h12, i) || sb_mid[i] !== ref_sel_b(8'h12, i)) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL busy_start_sel: bit3 sel=%h/%h want %h/%h", sa_mid[3], sb_mid[3],
                      ref_sel_a(8'h12, 3), ref_sel_b(8'h12, 3));
    end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL busy_start_single: extra_active=%0d want 0", n_done); end
  endtask

  task automatic test_random();
    int per [4];
    int lat, ia, ib;
    logic [7:0] s;
    logic [NB-1:0] er;
    logic exp_tie;
    bit ok;
    per[0] = 4; per[1] = 8; per[2] = 16; per[3] = 32;
    for (int r = 0; r < 5; r++) begin
      s = 8'($urandom_range(0, 255));
      er = '0;
      exp_tie = 1'b0;
      for (int i = 0; i < NB; i++) begin
        ia = $urandom_range(0, 3);
        ib = (ia + $urandom_range(1, 3)) % 4;
        pa_tab[i] = per[ia];
        pb_tab[i] = per[ib];
        same_tab[i] = ($urandom_range(0, 3) == 0);
        if (same_tab[i]) exp_tie = 1'b1;
        else if (ref_cnt(pa_tab[i]) > ref_cnt(pb_tab[i])) er[i] = 1'b1;
      end
      exp_q.push_back(er);
      run_cmd(s, 1'b0, lat);
      er = exp_q.pop_front();
      total++;
      if (lat != LAT || response !== er || tie !== exp_tie || sat !== 1'b0) begin
        bad++; $display("FAIL random_run%0d seed=%h: lat=%0d resp=%b tie=%b sat=%b want %0d %b %b 0",
                        r, s, lat, response, tie, sat, LAT, er, exp_tie);
      end
      ok = 1'b1;
      for (int i = 0; i < NB; i++)
        if (sa_mid[i] !== ref_sel_a(s, i) || sb_mid[i] !== ref_sel_b(s, i) || sa_mid[i] === sb_mid[i])
          ok = 1'b0;
      total++;
      if (!ok) begin
        bad++; $display("FAIL random_sel%0d seed=%h: bit0 sel=%h/%h want %h/%h", r, s,
                        sa_mid[0], sb_mid[0], ref_sel_a(s, 0), ref_sel_b(s, 0));
      end
      total++;
      if (same_tab[NB-1] ? (last_a !== last_b || last_a < 15'(ref_cnt(pa_tab[NB-1]) - 1) ||
                            last_a > 16'(ref_cnt(pa_tab[NB-1]) + 1))
                         : (last_a < 16'(ref_cnt(pa_tab[NB-1]) - 1) || last_a > 16'(ref_cnt(pa_tab[NB-1]) + 1) ||
                            last_b < 16'(ref_cnt(pb_tab[NB-1]) - 1) || last_b > 16'(ref_cnt(pb_tab[NB-1]) + 1))) begin
        bad++; $display("FAIL random_last%0d: last=%0d/%0d want %0d/%0d (+-1)", r, last_a, last_b,
                        ref_cnt(pa_tab[NB-1]), same_tab[NB-1] ? ref_cnt(pa_tab[NB-1]) : ref_cnt(pb_tab[NB-1]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    seed  = 8'h00;
    set_all(0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_challenge();
    test_tie_order();
    test_saturation();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_resp_ctrl.md
Name: puf_resp_ctrl

Overview:
Measurement controller that sits downstream of the ring-oscillator bank and 16:1 oscillator muxes. For each response bit it:
- drives a pair of mux selects;
- lets the selected oscillators settle;
- counts their rising edges over a fixed window of system clocks;
- compares the two counts and shifts the result into a multi-bit response register.

It replaces free-running, ripple-clocked counting with a synchronous, windowed, challenge-sequenced measurement.

Parameters:
NBITS, 16, number of response bits generated per start (1..32)
CW, 16, width of each edge counter
WIN_CYCLES, 1024, measurement window length in clk cycles (>=1)
SETTLE_CYCLES, 8, idle cycles after select change before counting (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-high
start  input  1  begin a response generation; sampled only in IDLE
seed  input  8  challenge seed; latched on accepted start
ro_a  input  1  raw (asynchronous) output of oscillator mux A
ro_b  input  1  raw (asynchronous) output of oscillator mux B
sel_a  output  4  select for mux A
sel_b  output  4  select for mux B
ro_en  output  1  oscillator enable
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when response is valid
response  output  NBITS  response bits, bit i = comparison i
tie  output  1  sticky: some comparison had count_a == count_b
sat  output  1  sticky: some counter saturated
last_a  output  CW  final count_a of most recent comparison
last_b  output  CW  final count_b of most recent comparison

Behaviour:
- Reset (rst_n=1, asynchronous, immediate, including mid-operation):
  - state=IDLE; all outputs 0 (sel_a, sel_b, ro_en, busy, done, response, tie, sat, last_a, last_b).
  - Synchronizers, counters and bit index are cleared.
- Input sampling:
  - ro_a and ro_b each pass through a 2-FF synchronizer, then a rising-edge detector (third FF).
  - One edge count per detected 0->1 transition.
  - Valid only for ro frequency < clk/2; faster inputs alias (documented limitation, not an error).
- Challenge for bit i (i = 0..NBITS-1):
  - sel_a = (seed[3:0] + i) mod 16.
  - sel_b = sel_a XOR k, where k = seed[7:4], or k = 4'h1 when seed[7:4] == 0.
  - sel_a never equals sel_b.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE: busy=0, ro_en=0.
  - On start=1: latch seed; clear response, tie, sat; i=0; go to SETTLE.
  - start while busy is ignored.
- SETTLE: ro_en=1, sel_a/sel_b hold the challenge for i, counters held at 0; lasts exactly SETTLE_CYCLES cycles, then MEASURE.
- MEASURE: lasts exactly WIN_CYCLES cycles.
  - Each cycle, each counter increments by 1 if its edge detector fires.
  - A counter stops at 2^CW-1; sat is set if an increment is attempted at that value.
- COMPARE: 1 cycle.
  - response[i] = (count_a > count_b); a tie gives 0 and sets tie.
  - last_a/last_b are loaded; counters are cleared.
  - If i == NBITS-1 go to DONE, else i=i+1 and go to SETTLE.
- DONE: 1 cycle with done=1, ro_en=0, busy=0; then IDLE.
- busy timing: busy=1 in SETTLE, MEASURE and COMPARE.
- Hold behaviour: response, tie, sat, last_a and last_b hold until the next accepted start or reset. sel_a/sel_b hold their last value in IDLE.
- Latency: done asserts NBITS*(SETTLE_CYCLES+WIN_CYCLES+1)+1 cycles after the cycle start is sampled.
- Comparison is unsigned, full CW width.

Test Plan:
- Reset mid-MEASURE: assert rst_n during bit 3 -> same cycle busy=0, ro_en=0, response=0; after release, stays IDLE until start.
- Basic compare (WIN_CYCLES=64, SETTLE=8, NBITS=4): ro_a = clk/4 square, ro_b = clk/8, seed=8'h00.
  - done at cycle 4*73+1=293; response=4'b1111; last_a=16±1, last_b=8±1; tie=0.
- Challenge sequence: seed=8'h3E, NBITS=4 -> sel_a steps E,F,0,1; sel_b steps D,C,3,2 (XOR 3), each held through SETTLE+MEASURE.
- Zero key, tie and ordering: seed=8'h05 -> sel_b = sel_a^1.
  - Identical ro_a and ro_b streams -> response=0, tie=1.
  - ro_b faster than ro_a -> response=0, tie=0.
- Saturation: CW=4, WIN=64, ro_a = clk/4 -> last_a=15, sat=1; response bit still 1 if ro_b is idle.
- start during busy: pulse start mid-run -> ignored, done pulses exactly once at the original latency; a new start in IDLE clears tie and sat.
